exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Multicycle control FSM for the single-cycle MIPS datapath. It spreads each instruction over fetch / decode / execute / memory / writeback steps.
- It shares the single memory port between instruction fetch and load/store.
- It generates all state-update strobes (IR, PC, GPR, memory write) in place of the free-running clock-enable.
- It detects the halt instruction and memory-ack timeouts, and keeps cycle and retired-instruction counters.

Parameters:
- CNT_W, 32, width of cycle_cnt and retired_cnt.
- ACK_TIMEOUT, 255, cycles waited in FETCH/MEM without mem_ack before entering ERR.
- TMO_W, 8, width of the ack-wait counter; must satisfy 2^TMO_W > ACK_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; leaves IDLE.
- mem_ack  in  1  memory access complete this cycle.
- halt_in  in  1  decoded instruction is the halt encoding (all zeros).
- is_load  in  1  decoder: instruction reads data memory.
- is_store  in  1  decoder: instruction writes data memory (DM_WE).
- gp_we_dec  in  1  decoder: instruction writes a GPR.
- mem_req  out  1  memory access request.
- mem_addr_sel  out  1  0 = address from PC, 1 = address from ALU result.
- mem_we  out  1  memory write enable.
- ir_we  out  1  latch fetched instruction.
- pc_we  out  1  load next_pc into PC.
- gpr_we  out  1  register file write strobe.
- state  out  3  current FSM state code.
- halted  out  1  FSM in HALT.
- timeout_err  out  1  FSM in ERR.
- cycle_cnt  out  CNT_W  active cycles.
- retired_cnt  out  CNT_W  completed instructions.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, all counters 0, all outputs 0.
  - Reset asserted mid-access drops mem_req immediately; no write strobe completes.
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- IDLE: start=1 -> FETCH next edge. All other inputs ignored.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - On mem_ack: ir_we=1 in that same cycle (combinational on mem_ack), then -> DECODE.
- DECODE (1 cycle): halt_in=1 -> HALT, else -> EXEC. No strobes.
- EXEC (1 cycle): (is_load | is_store) -> MEM, else -> WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=is_store.
  - If is_load and is_store are both 1, store wins (mem_we=1).
  - On mem_ack -> WB.
- WB (1 cycle): gpr_we=gp_we_dec, pc_we=1, retired_cnt+1, then -> FETCH.
- HALT:
  - halted=1. pc_we is never asserted, so PC stays on the halt instruction.
  - Sticky until reset; start is ignored.
- Ack timeout:
  - Wait counter clears on entry to FETCH/MEM and counts each cycle without mem_ack.
  - When it equals ACK_TIMEOUT -> ERR.
  - mem_ack in the same cycle as the limit: ack wins, normal transition.
- ERR: timeout_err=1, mem_req=0. Sticky until reset.
- mem_ack outside FETCH/MEM is ignored.
- cycle_cnt increments in every state except IDLE/HALT/ERR. Both counters wrap modulo 2^CNT_W.
- Latency: non-memory instruction = 4 cycles + fetch wait; load/store = 5 cycles + both waits; with zero-wait memory these are 4 and 5.
- Strobe outputs are Moore decodes of state, except ir_we, which is Mealy on mem_ack.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input step_mode (1 bit).
  - With step_mode=1, WB goes to IDLE instead of FETCH, so each start pulse executes exactly one instruction.
  - step_mode is sampled in WB.
- Undefined: port absent; WB always goes to FETCH.

Decomposition:
- Package seq_pkg holds:
  - the 3-bit state typedef with the codes above;
  - the STATE_W constant;
  - default CNT_W / ACK_TIMEOUT values.
- One sub-module, seq_ack_timer:
  - TMO_W-bit wait counter with clear, enable and ack inputs;
  - expire output = (count == ACK_TIMEOUT) & ~ack.
- FSM and counters stay in exec_sequencer.

Test Plan:
- Reset, then start, ALU op, mem_ack=1 at first FETCH cycle, halt_in=0 -> states 1,2,3,5,1. ir_we high in cycle 1, pc_we and gpr_we high in cycle 4, retired_cnt=1, cycle_cnt=4.
- Load with is_load=1, mem_ack delayed 3 cycles in MEM -> mem_addr_sel=1 and mem_we=0 for 4 cycles. gpr_we=1 in WB; 5+3 cycles to retire.
- Store with is_store=1, gp_we_dec=0 -> mem_we=1 throughout MEM, gpr_we=0 in WB, pc_we=1.
- halt_in=1 at DECODE -> HALT, halted=1, pc_we never asserted. start pulse ignored; cycle_cnt frozen.
- mem_ack withheld with ACK_TIMEOUT=4 -> ERR after 5 FETCH cycles, mem_req drops, timeout_err=1. Repeat with ack on the 5th cycle -> DECODE, no error.
- rst=0 asserted mid-MEM with is_store=1 -> mem_we/mem_req low immediately, state=0, counters 0. With SEQ_SINGLE_STEP_EN and step_mode=1, each start retires exactly one instruction and returns to IDLE.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and defaults for the multicycle execution sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_pkg;

    localparam int STATE_W         = 3;
    localparam int CNT_W_DEF       = 32;
    localparam int ACK_TIMEOUT_DEF = 255;
    localparam int TMO_W_DEF       = 8;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

endpackage

// File: rtl/exec_sequencer_if.sv
// Shared memory port between the sequencer (master) and memory (slave).
// Latency: combinational wires only.
// Backpressure: memory holds off completion by withholding mem_ack.
interface exec_sequencer_if;
    logic mem_req;
    logic mem_addr_sel;
    logic mem_we;
    logic mem_ack;

    modport master (output mem_req, output mem_addr_sel, output mem_we, input mem_ack);
    modport slave  (input mem_req, input mem_addr_sel, input mem_we, output mem_ack);
endinterface

// File: rtl/seq_ack_timer.sv
// Counts cycles spent waiting for mem_ack; flags when the wait limit is reached.
// Latency: expire is combinational from the registered count and ack.
// Backpressure: none; a same-cycle ack always suppresses expire.
module seq_ack_timer #(
    parameter int TMO_W       = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic ack,
    output logic expire
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(ACK_TIMEOUT);
    localparam logic [TMO_W-1:0] ONE   = TMO_W'(1);

    logic [TMO_W-1:0] count;

    // Wait counter: cleared on state entry, saturates at the limit so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && !ack && (count != LIMIT))
            count <= count + ONE;
    end

    assign expire = (count == LIMIT) & ~ack;

endmodule

// File: rtl/exec_sequencer.sv
// Multicycle control FSM: fetch/decode/exec/mem/wb over one shared memory port.
// Latency: 4 cycles per ALU op, 5 per load/store, plus memory wait cycles.
// Backpressure: stalls in FETCH/MEM until mem_ack; goes to ERR after ACK_TIMEOUT.
// Optional SEQ_SINGLE_STEP_EN adds step_mode: WB returns to IDLE instead of FETCH.
module exec_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int TMO_W       = TMO_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    exec_sequencer_if.master    mbus,
    input  logic                start,
    input  logic                halt_in,
    input  logic                is_load,
    input  logic                is_store,
    input  logic                gp_we_dec,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                step_mode,
`endif
    output logic                ir_we,
    output logic                pc_we,
    output logic                gpr_we,
    output logic [STATE_W-1:0]  state,
    output logic                halted,
    output logic                timeout_err,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    retired_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t cur, nxt;
    logic   req, sel, we, expire, step;

`ifdef SEQ_SINGLE_STEP_EN
    assign step = step_mode;
`else
    assign step = 1'b0;
`endif

    seq_ack_timer #(.TMO_W(TMO_W), .ACK_TIMEOUT(ACK_TIMEOUT)) u_tmr (
        .clk    (clk),
        .rst    (rst),
        .clr    (nxt != cur),
        .en     ((cur == S_FETCH) || (cur == S_MEM)),
        .ack    (mbus.mem_ack),
        .expire (expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cur <= S_IDLE;
        else
            cur <= nxt;
    end

    // Next-state and strobe decode; ir_we is the only output that looks at mem_ack.
    always_comb begin
        nxt    = cur;
        req    = 1'b0;
        sel    = 1'b0;
        we     = 1'b0;
        ir_we  = 1'b0;
        pc_we  = 1'b0;
        gpr_we = 1'b0;
        case (cur)
            S_IDLE:   if (start) nxt = S_FETCH;
            S_FETCH: begin
                req = 1'b1;
                if (mbus.mem_ack) begin
                    ir_we = 1'b1;
                    nxt   = S_DECODE;
                end else if (expire) begin
                    nxt = S_ERR;
                end
            end
            S_DECODE: nxt = halt_in ? S_HALT : S_EXEC;
            S_EXEC:   nxt = (is_load | is_store) ? S_MEM : S_WB;
            S_MEM: begin
                req = 1'b1;
                sel = 1'b1;
                we  = is_store;   // store wins if the decoder flags both
                if (mbus.mem_ack)
                    nxt = S_WB;
                else if (expire)
                    nxt = S_ERR;
            end
            S_WB: begin
                pc_we  = 1'b1;
                gpr_we = gp_we_dec;
                nxt    = step ? S_IDLE : S_FETCH;
            end
            S_HALT:   nxt = S_HALT;
            S_ERR:    nxt = S_ERR;
            default:  nxt = S_IDLE;
        endcase
    end

    assign mbus.mem_req      = req;
    assign mbus.mem_addr_sel = sel;
    assign mbus.mem_we       = we;
    assign state             = cur;
    assign halted            = (cur == S_HALT);
    assign timeout_err       = (cur == S_ERR);

    // Active-cycle counter: frozen while idle, halted or in error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cycle_cnt <= '0;
        else if ((cur != S_IDLE) && (cur != S_HALT) && (cur != S_ERR))
            cycle_cnt <= cycle_cnt + CNT_ONE;
    end

    // Retired-instruction counter: one per writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            retired_cnt <= '0;
        else if (cur == S_WB)
            retired_cnt <= retired_cnt + CNT_ONE;
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: per-cycle expectations go to a queue,
// a negedge monitor pops and compares state, strobes and counters.
// Built with ACK_TIMEOUT=4 so timeout paths are short.
module tb_exec_sequencer;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, halt_in = 1'b0, is_load = 1'b0, is_store = 1'b0, gp_we_dec = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step_mode = 1'b0;
`endif
    logic        ir_we, pc_we, gpr_we, halted, timeout_err;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, retired_cnt;

    exec_sequencer_if mif();

    exec_sequencer #(.CNT_W(32), .ACK_TIMEOUT(4), .TMO_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .mbus        (mif),
        .start       (start),
        .halt_in     (halt_in),
        .is_load     (is_load),
        .is_store    (is_store),
        .gp_we_dec   (gp_we_dec),
`ifdef SEQ_SINGLE_STEP_EN
        .step_mode   (step_mode),
`endif
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .gpr_we      (gpr_we),
        .state       (state),
        .halted      (halted),
        .timeout_err (timeout_err),
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [7:0]  strb;   // {req, sel, we, ir, pc, gpr, halted, err}
        logic [31:0] cyc;
        logic [31:0] ret;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] m_cyc = 0;
    logic [31:0] m_ret = 0;

    task automatic push(input string tag, input state_t st, input logic ack,
                        input logic gpw, input logic sto);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.strb = {(st == S_FETCH) || (st == S_MEM), st == S_MEM, (st == S_MEM) && sto,
                  (st == S_FETCH) && ack, st == S_WB, (st == S_WB) && gpw,
                  st == S_HALT, st == S_ERR};
        e.cyc  = m_cyc;
        e.ret  = m_ret;
        q.push_back(e);
    endtask

    // One clock cycle: drive inputs, record what this cycle must look like, advance.
    task automatic cyc(input string tag, input state_t st, input logic s, input logic ack,
                       input logic hlt, input logic ld, input logic sto, input logic gpw);
        start = s; mif.mem_ack = ack; halt_in = hlt;
        is_load = ld; is_store = sto; gp_we_dec = gpw;
        push(tag, st, ack, gpw, sto);
        @(posedge clk); #1;
        if (!(st inside {S_IDLE, S_HALT, S_ERR})) m_cyc = m_cyc + 1;
        if (st == S_WB) m_ret = m_ret + 1;
        start = 1'b0;
    endtask

    // Reset asserted mid-cycle: outputs must drop before the next edge.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        m_cyc = 0;
        m_ret = 0;
        push(tag, S_IDLE, 1'b0, 1'b0, 1'b0);
        #1;
        n_vec++;
        if (state !== 3'd0 || mif.mem_req !== 1'b0 || mif.mem_we !== 1'b0 ||
            cycle_cnt !== 32'd0 || retired_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL %s immediate: st=%0d req=%b we=%b cyc=%0d ret=%0d",
                     tag, state, mif.mem_req, mif.mem_we, cycle_cnt, retired_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Monitor: compares one expectation per cycle at the falling edge.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] got;
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = {mif.mem_req, mif.mem_addr_sel, mif.mem_we, ir_we, pc_we, gpr_we,
                   halted, timeout_err};
            n_vec++;
            if (state !== e.st || got !== e.strb || cycle_cnt !== e.cyc || retired_cnt !== e.ret) begin
                n_bad++;
                $display("FAIL %s: got st=%0d strb=%b cyc=%0d ret=%0d, want st=%0d strb=%b cyc=%0d ret=%0d",
                         e.tag, state, got, cycle_cnt, retired_cnt, e.st, e.strb, e.cyc, e.ret);
            end
        end
    end

    initial begin
        mif.mem_ack = 1'b0;
        @(posedge clk); #1;
        do_reset("reset");

        // ALU op, zero-wait fetch
        cyc("alu_idle",  S_IDLE,   1,0,0,0,0,1);
        cyc("alu_fetch", S_FETCH,  0,1,0,0,0,1);
        cyc("alu_dec",   S_DECODE, 0,0,0,0,0,1);
        cyc("alu_exec",  S_EXEC,   0,0,0,0,0,1);
        cyc("alu_wb",    S_WB,     0,0,0,0,0,1);

        // Load, ack withheld 3 cycles in MEM; stray ack in DECODE ignored
        cyc("ld_fetch",  S_FETCH,  0,1,0,1,0,1);
        cyc("ld_dec",    S_DECODE, 0,1,0,1,0,1);
        cyc("ld_exec",   S_EXEC,   0,0,0,1,0,1);
        cyc("ld_mem0",   S_MEM,    0,0,0,1,0,1);
        cyc("ld_mem1",   S_MEM,    0,0,0,1,0,1);
        cyc("ld_mem2",   S_MEM,    0,0,0,1,0,1);
        cyc("ld_mem3",   S_MEM,    0,1,0,1,0,1);
        cyc("ld_wb",     S_WB,     0,0,0,1,0,1);

        // Store with load also flagged: store wins, no GPR write
        cyc("st_fetch",  S_FETCH,  0,1,0,1,1,0);
        cyc("st_dec",    S_DECODE, 0,0,0,1,1,0);
        cyc("st_exec",   S_EXEC,   0,0,0,1,1,0);
        cyc("st_mem0",   S_MEM,    0,0,0,1,1,0);
        cyc("st_mem1",   S_MEM,    0,1,0,1,1,0);
        cyc("st_wb",     S_WB,     0,0,0,1,1,0);

        // Halt: sticky, start and ack ignored, counters frozen
        cyc("h_fetch",   S_FETCH,  0,1,0,0,0,0);
        cyc("h_dec",     S_DECODE, 0,0,1,0,0,0);
        cyc("h_halt0",   S_HALT,   0,0,1,0,0,0);
        cyc("h_start",   S_HALT,   1,0,0,0,0,0);
        cyc("h_ack",     S_HALT,   0,1,0,0,0,0);
        cyc("h_halt1",   S_HALT,   0,0,0,0,0,0);

        // Fetch timeout: 5 cycles without ack -> ERR, sticky
        do_reset("rst_tmo");
        cyc("t_idle",    S_IDLE,   1,0,0,0,0,0);
        for (int i = 0; i < 5; i++)
            cyc("t_fetch", S_FETCH, 0,0,0,0,0,0);
        n_vec++;
        if (state !== S_ERR || timeout_err !== 1'b1 || mif.mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL t_expired: st=%0d timeout_err=%b req=%b",
                     state, timeout_err, mif.mem_req);
        end
        cyc("t_err0",    S_ERR,    0,0,0,0,0,0);
        cyc("t_err1",    S_ERR,    1,1,0,0,0,0);

        // Ack on the limit cycle wins; then reset in the middle of a store
        do_reset("rst_lim");
        cyc("l_idle",    S_IDLE,   1,0,0,0,0,0);
        for (int i = 0; i < 4; i++)
            cyc("l_fetch", S_FETCH, 0,0,0,0,0,0);
        cyc("l_fetch_ack", S_FETCH, 0,1,0,0,1,0);
        cyc("l_dec",     S_DECODE, 0,0,0,0,1,0);
        cyc("l_exec",    S_EXEC,   0,0,0,0,1,0);
        cyc("l_mem",     S_MEM,    0,0,0,0,1,0);
        do_reset("rst_mid_mem");
        cyc("post_rst",  S_IDLE,   0,0,0,0,0,0);

`ifdef SEQ_SINGLE_STEP_EN
        // Single-step: each start retires exactly one instruction
        step_mode = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc("s_idle",  S_IDLE,   1,0,0,0,0,1);
            cyc("s_fetch", S_FETCH,  0,1,0,0,0,1);
            cyc("s_dec",   S_DECODE, 0,0,0,0,0,1);
            cyc("s_exec",  S_EXEC,   0,0,0,0,0,1);
            cyc("s_wb",    S_WB,     0,0,0,0,0,1);
            cyc("s_back",  S_IDLE,   0,0,0,0,0,1);
        end
`endif

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
